// File: rtl/ad5542_spi_rx_if.sv
// Signal bundle between an AD5542-style SPI write port and the word consumer.
// master: drives the SPI pins and rx_ready; slave: the receiver.
interface ad5542_spi_rx_if #(
    parameter int DATA_W = 16
) ();
    logic              spi_clk;
    logic              spi_cs_n;
    logic              spi_din;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_frame_err;
    logic              rx_ovf;

    modport master (
        output spi_clk, spi_cs_n, spi_din, rx_ready,
        input  rx_data, rx_valid, rx_frame_err, rx_ovf
    );

    modport slave (
        input  spi_clk, spi_cs_n, spi_din, rx_ready,
        output rx_data, rx_valid, rx_frame_err, rx_ovf
    );
endinterface

// File: rtl/ad5542_spi_rx.sv
// Oversampling SPI write-port receiver (SCLK idle high, MSB first, DATA_W-bit frames).
// Define AD5542_SPI_RX_FRAME_CNT_EN to add the rx_frame_cnt good-frame counter port.
//
// state     | meaning
// WAIT_IDLE | after reset, wait for CS_N high so a frame in flight is ignored
// IDLE      | CS_N high, waiting for CS_N fall
// RECV      | CS_N low, shifting on SCLK rise; frame judged on CS_N rise
module ad5542_spi_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    ad5542_spi_rx_if.slave   bus
`ifdef AD5542_SPI_RX_FRAME_CNT_EN
    ,
    output logic [15:0]      rx_frame_cnt
`endif
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s, cs_s, din_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    logic [DATA_W-1:0] shift, shift_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt, err_nxt, ovf_nxt, good_frame;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    // CS_N chain resets low so WAIT_IDLE only leaves on a genuinely high pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            cs_sync   <= '0;
            din_sync  <= '0;
            sclk_q    <= 1'b1;
            cs_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], bus.spi_din};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= WAIT_IDLE;
            shift            <= '0;
            cnt              <= '0;
            bus.rx_data      <= '0;
            bus.rx_valid     <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_ovf       <= 1'b0;
        end else begin
            state            <= state_nxt;
            shift            <= shift_nxt;
            cnt              <= cnt_nxt;
            bus.rx_data      <= data_nxt;
            bus.rx_valid     <= valid_nxt;
            bus.rx_frame_err <= err_nxt;
            bus.rx_ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        cnt_nxt    = cnt;
        data_nxt   = bus.rx_data;
        valid_nxt  = bus.rx_valid & ~bus.rx_ready;
        err_nxt    = 1'b0;
        ovf_nxt    = 1'b0;
        good_frame = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (cs_s)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = RECV;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            RECV: begin
                // A SCLK rise coincident with the CS_N rise still belongs to this frame.
                if (sclk_rise) begin
                    shift_nxt = {shift[DATA_W-2:0], din_s};
                    if (cnt != CNT_SAT)
                        cnt_nxt = cnt + 1'b1;
                end
                if (cs_rise) begin
                    state_nxt = IDLE;
                    if (cnt_nxt == CNT_FULL) begin
                        good_frame = 1'b1;
                        if (!bus.rx_valid || bus.rx_ready) begin
                            data_nxt  = shift_nxt;
                            valid_nxt = 1'b1;
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

`ifdef AD5542_SPI_RX_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_frame_cnt <= '0;
        else if (good_frame)
            rx_frame_cnt <= rx_frame_cnt + 16'd1;
    end
`else
    logic unused_good;
    assign unused_good = good_frame;
`endif
endmodule

// File: tb/tb_ad5542_spi_rx.sv
// Directed bench for ad5542_spi_rx: drives SPI frames and checks delivered words and pulses.
module tb_ad5542_spi_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   err_seen = 0;
    int   ovf_seen = 0;
    int   n;
    logic [15:0] acc_q[$];
`ifdef AD5542_SPI_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    ad5542_spi_rx_if #(.DATA_W(16)) bus ();

    ad5542_spi_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef AD5542_SPI_RX_FRAME_CNT_EN
        ,
        .rx_frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) begin
            acc_cnt++;
            acc_q.push_back(bus.rx_data);
        end
        if (bus.rx_frame_err) err_seen++;
        if (bus.rx_ovf) ovf_seen++;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.spi_clk = 1'b0;
        bus.spi_din = b;
        tick(4);
        bus.spi_clk = 1'b1;
        tick(4);
    endtask

    // 8-clk SCLK period, CS_N high for one SCLK period afterwards
    task automatic send_frame(input logic [31:0] val, input int nbits);
        bus.spi_cs_n = 1'b0;
        tick(4);
        for (int i = nbits - 1; i >= 0; i--)
            send_bit(val[i]);
        bus.spi_cs_n = 1'b1;
        bus.spi_din  = 1'b0;
        tick(8);
    endtask

    initial begin
        logic [15:0] partial;
        bus.spi_clk  = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_din  = 1'b0;
        bus.rx_ready = 1'b1;
        tick(4);
        check("reset_data",  {16'h0, bus.rx_data}, 32'h0);
        check("reset_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("reset_err",   {31'h0, bus.rx_frame_err}, 32'h0);
        check("reset_ovf",   {31'h0, bus.rx_ovf}, 32'h0);
        rst = 1'b0;
        tick(6);

        // basic word with consumer ready
        send_frame(32'hA5C3, 16);
        check("t1_acc_cnt", acc_cnt, 1);
        check("t1_word",    {16'h0, acc_q[acc_q.size()-1]}, 32'hA5C3);
        check("t1_data",    {16'h0, bus.rx_data}, 32'hA5C3);
        check("t1_valid",   {31'h0, bus.rx_valid}, 32'h0);
        check("t1_err",     err_seen, 0);
        check("t1_ovf",     ovf_seen, 0);

        // buffer full: second word dropped
        bus.rx_ready = 1'b0;
        send_frame(32'h1234, 16);
        check("t2_valid_held", {31'h0, bus.rx_valid}, 32'h1);
        check("t2_data_held",  {16'h0, bus.rx_data}, 32'h1234);
        send_frame(32'hFFFF, 16);
        check("t2_data_kept",  {16'h0, bus.rx_data}, 32'h1234);
        check("t2_valid_kept", {31'h0, bus.rx_valid}, 32'h1);
        check("t2_ovf",        ovf_seen, 1);
        bus.rx_ready = 1'b1;
        tick(1);
        check("t2_valid_fall", {31'h0, bus.rx_valid}, 32'h0);
        check("t2_acc_cnt",    acc_cnt, 2);
        check("t2_word",       {16'h0, acc_q[acc_q.size()-1]}, 32'h1234);

        // short and long frames
        send_frame(32'h7FFF, 15);
        check("t3_err15", err_seen, 1);
        send_frame(32'h1FFFF, 17);
        check("t3_err17", err_seen, 2);
        check("t3_no_acc", acc_cnt, 2);
        send_frame(32'h8001, 16);
        check("t3_word", {16'h0, acc_q[acc_q.size()-1]}, 32'h8001);
        check("t3_acc_cnt", acc_cnt, 3);
        check("t3_ovf", ovf_seen, 1);

        // empty frame, then all-zero word
        bus.spi_cs_n = 1'b0;
        tick(8);
        bus.spi_cs_n = 1'b1;
        tick(8);
        check("t4_err_empty", err_seen, 3);
        bus.rx_ready = 1'b0;
        send_frame(32'h0000, 16);
        check("t4_valid", {31'h0, bus.rx_valid}, 32'h1);
        check("t4_data",  {16'h0, bus.rx_data}, 32'h0000);
        bus.rx_ready = 1'b1;
        tick(2);
        check("t4_acc_cnt", acc_cnt, 4);

        // reset in the middle of 0x5555, released with CS_N still low
        partial = 16'h5555;
        bus.spi_cs_n = 1'b0;
        tick(4);
        for (int i = 15; i >= 8; i--)
            send_bit(partial[i]);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 7; i >= 0; i--)
            send_bit(partial[i]);
        bus.spi_cs_n = 1'b1;
        bus.spi_din  = 1'b0;
        tick(8);
        check("t5_no_acc",  acc_cnt, 4);
        check("t5_no_err",  err_seen, 3);
        check("t5_data_clr", {16'h0, bus.rx_data}, 32'h0);
        send_frame(32'h00FF, 16);
        check("t5_word", {16'h0, acc_q[acc_q.size()-1]}, 32'h00FF);
        check("t5_acc_cnt", acc_cnt, 5);

        // back-to-back frames from a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        send_frame(32'h0001, 16);
        send_frame(32'h8000, 16);
        n = acc_q.size();
        check("t6_acc_cnt", acc_cnt, 7);
        check("t6_first",  {16'h0, acc_q[n-2]}, 32'h0001);
        check("t6_second", {16'h0, acc_q[n-1]}, 32'h8000);
        check("t6_err", err_seen, 3);
`ifdef AD5542_SPI_RX_FRAME_CNT_EN
        check("t6_frame_cnt", {16'h0, frame_cnt}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
